// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the WISC pipeline control slice.
// Tracker entry, control FSM states and the zero-register id.
package pipe_ctrl_pkg;

  // Register ids are stored zero-extended so the entry type stays fixed
  localparam int RID_W = 8;

  typedef logic [RID_W-1:0] rid_t;

  localparam rid_t ZERO_REG = '0;

  typedef struct packed {
    logic valid;
    rid_t rd;
    logic wr;
    logic is_load;
  } hz_entry_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } ctrl_state_t;

endpackage

// File: rtl/hz_src_match.sv
// hz_src_match: scans the tracker for one source operand.
// In: ent_i tracker, src_i, used_i. Out: hit_o, idx_o youngest, load_o.
module hz_src_match
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  hz_entry_t [DEPTH-1:0] ent_i,
  input  rid_t                  src_i,
  input  logic                  used_i,
  output logic                  hit_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  load_o
);

  // Walk oldest to youngest so the lowest index overwrites last
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    load_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_i[i].valid && ent_i[i].wr &&
          ent_i[i].rd == src_i && used_i &&
          src_i != ZERO_REG) begin
        hit_o  = 1'b1;
        idx_o  = SEL_W'(i);
        load_o = ent_i[i].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: tag scoreboard for EX..WB writers; drives stall,
// bubble, flush, forward selects, halt drain and memory-busy freeze.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int FWD_EN     = 1,
  parameter int LOAD_LAT   = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_rs_used_i,
  input  logic                  id_rt_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_wr_i,
  input  logic                  id_is_load_i,
  input  logic                  id_is_halt_i,
  input  logic                  redirect_i,
  input  logic                  mem_busy_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  bubble_ex_o,
  output logic                  flush_ifid_o,
  output logic [SEL_W-1:0]      fwd_sel_a_o,
  output logic [SEL_W-1:0]      fwd_sel_b_o,
  output logic [SEL_W-1:0]      inflight_cnt_o,
  output logic                  halt_o
);

  hz_entry_t [DEPTH-1:0] ent_q, ent_d;
  ctrl_state_t           state_q, state_d;
  logic                  halt_q, halt_d;

  logic             hit_a, hit_b;
  logic             ld_a, ld_b;
  logic [SEL_W-1:0] idx_a, idx_b;
  logic             stall_a, stall_b;
  logic             raw_stall, issue;
  logic             tail_busy;
  logic [SEL_W-1:0] cnt;

  hz_src_match #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match_a (
    .ent_i  (ent_q),
    .src_i  (rid_t'(id_rs_i)),
    .used_i (id_rs_used_i),
    .hit_o  (hit_a),
    .idx_o  (idx_a),
    .load_o (ld_a)
  );

  hz_src_match #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match_b (
    .ent_i  (ent_q),
    .src_i  (rid_t'(id_rt_i)),
    .used_i (id_rt_used_i),
    .hit_o  (hit_b),
    .idx_o  (idx_b),
    .load_o (ld_b)
  );

  // With forwarding only a load still short of LOAD_LAT blocks
  assign stall_a = (FWD_EN == 0) ? hit_a :
    (hit_a && ld_a && (int'(idx_a) < LOAD_LAT));
  assign stall_b = (FWD_EN == 0) ? hit_b :
    (hit_b && ld_b && (int'(idx_b) < LOAD_LAT));
  assign raw_stall = stall_a || stall_b;

  assign issue = id_valid_i && !raw_stall && !redirect_i &&
                 state_q == RUN && !mem_busy_i;

  assign fwd_sel_a_o = (FWD_EN != 0 && hit_a) ?
    idx_a + SEL_W'(1) : '0;
  assign fwd_sel_b_o = (FWD_EN != 0 && hit_b) ?
    idx_b + SEL_W'(1) : '0;

  always_comb begin
    cnt       = '0;
    tail_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + SEL_W'(ent_q[i].valid);
    end
    // All but WB: if none valid, the tracker is empty after this edge
    for (int i = 0; i < DEPTH - 1; i++) begin
      tail_busy = tail_busy | ent_q[i].valid;
    end
  end

  assign inflight_cnt_o = cnt;
  assign halt_o         = halt_q;

  always_comb begin
    ent_d   = ent_q;
    state_d = state_q;
    halt_d  = halt_q;
    if (!mem_busy_i) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        ent_d[i] = ent_q[i-1];
      end
      ent_d[0] = '0;
      if (issue) begin
        ent_d[0].valid   = 1'b1;
        ent_d[0].rd      = rid_t'(id_rd_i);
        ent_d[0].wr      = id_wr_i && !id_is_halt_i;
        ent_d[0].is_load = id_is_load_i;
      end
      unique case (state_q)
        RUN: begin
          if (issue && id_is_halt_i) state_d = DRAIN;
        end
        DRAIN: begin
          if (!tail_busy) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_if_o   = 1'b0;
    stall_id_o   = 1'b0;
    bubble_ex_o  = 1'b0;
    flush_ifid_o = 1'b0;
    priority case (1'b1)
      mem_busy_i: begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
      end
      state_q == HALTED: begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
      end
      state_q == DRAIN: begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        bubble_ex_o = 1'b1;
      end
      redirect_i: begin
        flush_ifid_o = 1'b1;
        bubble_ex_o  = 1'b1;
      end
      raw_stall: begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        bubble_ex_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl with a
// forwarding instance and a no-forwarding instance on shared inputs.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, rs_used, rt_used;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       id_wr, id_ld, id_hlt;
  logic       redirect, mem_busy;

  logic       a_sif, a_sid, a_bub, a_fl, a_halt;
  logic [1:0] a_fa, a_fb, a_cnt;
  logic       b_sif, b_sid, b_bub, b_fl, b_halt;
  logic [1:0] b_fa, b_fb, b_cnt;

  pipe_hazard_ctrl u_a (
    .clk            (clk),
    .rst            (rst),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_rs_used_i   (rs_used),
    .id_rt_used_i   (rt_used),
    .id_rd_i        (id_rd),
    .id_wr_i        (id_wr),
    .id_is_load_i   (id_ld),
    .id_is_halt_i   (id_hlt),
    .redirect_i     (redirect),
    .mem_busy_i     (mem_busy),
    .stall_if_o     (a_sif),
    .stall_id_o     (a_sid),
    .bubble_ex_o    (a_bub),
    .flush_ifid_o   (a_fl),
    .fwd_sel_a_o    (a_fa),
    .fwd_sel_b_o    (a_fb),
    .inflight_cnt_o (a_cnt),
    .halt_o         (a_halt)
  );

  pipe_hazard_ctrl #(.FWD_EN(0)) u_b (
    .clk            (clk),
    .rst            (rst),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_rs_used_i   (rs_used),
    .id_rt_used_i   (rt_used),
    .id_rd_i        (id_rd),
    .id_wr_i        (id_wr),
    .id_is_load_i   (id_ld),
    .id_is_halt_i   (id_hlt),
    .redirect_i     (redirect),
    .mem_busy_i     (mem_busy),
    .stall_if_o     (b_sif),
    .stall_id_o     (b_sid),
    .bubble_ex_o    (b_bub),
    .flush_ifid_o   (b_fl),
    .fwd_sel_a_o    (b_fa),
    .fwd_sel_b_o    (b_fb),
    .inflight_cnt_o (b_cnt),
    .halt_o         (b_halt)
  );

  logic [10:0] vec_a, vec_b;
  assign vec_a = {a_sif, a_sid, a_bub, a_fl, a_fa, a_fb, a_cnt, a_halt};
  assign vec_b = {b_sif, b_sid, b_bub, b_fl, b_fa, b_fb, b_cnt, b_halt};

  typedef struct {
    string       tag;
    bit          sel;
    logic [10:0] exp;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  function automatic logic [10:0] ev(
    input bit sif, input bit sid, input bit bub, input bit fl,
    input int fa, input int fb, input int cnt, input bit h);
    return {sif, sid, bub, fl, 2'(fa), 2'(fb), 2'(cnt), h};
  endfunction

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; rs_used = 0; rt_used = 0;
    id_rd = 0; id_wr = 0; id_ld = 0; id_hlt = 0;
    redirect = 0; mem_busy = 0;
  endtask

  task automatic instr(input bit v, input int rs, input bit rsu,
    input int rt, input bit rtu, input int rd, input bit wr,
    input bit ld, input bit hlt);
    id_valid = v; id_rs = 4'(rs); rs_used = rsu;
    id_rt = 4'(rt); rt_used = rtu; id_rd = 4'(rd);
    id_wr = wr; id_ld = ld; id_hlt = hlt;
  endtask

  task automatic chk(input string tag, input bit sel,
    input logic [10:0] e);
    sb_t s, got;
    logic [10:0] obs;
    s.tag = tag; s.sel = sel; s.exp = e;
    sb.push_back(s);
    @(negedge clk);
    got = sb.pop_front();
    obs = got.sel ? vec_b : vec_a;
    total++;
    assert (obs === got.exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", got.tag, obs, got.exp);
    end
    @(posedge clk);
    #1;
  endtask

  // A taken branch can never coexist with a draining halt
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(redirect && u_a.state_q == DRAIN)) else begin
        bad++;
        $error("FAIL redirect_in_drain observed=1 expected=0");
      end
    end
  end

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", 0, ev(0,0,0,0,0,0,0,0));
    rst = 0;
    chk("reset", 0, ev(0,0,0,0,0,0,0,0));

    instr(1, 2,1, 3,1, 1,1,0,0);
    chk("alu_first", 0, ev(0,0,0,0,0,0,0,0));
    instr(1, 1,1, 3,1, 2,1,0,0);
    chk("alu_fwd1", 0, ev(0,0,0,0,1,0,1,0));
    instr(1, 1,1, 2,1, 5,1,0,0);
    chk("alu_fwd2", 0, ev(0,0,0,0,2,1,2,0));
    idle();
    chk("alu_cnt3", 0, ev(0,0,0,0,0,0,3,0));
    chk("alu_cnt2", 0, ev(0,0,0,0,0,0,2,0));
    chk("alu_cnt1", 0, ev(0,0,0,0,0,0,1,0));

    instr(1, 6,1, 0,0, 4,1,1,0);
    chk("lw_issue", 0, ev(0,0,0,0,0,0,0,0));
    instr(1, 4,1, 4,1, 5,1,0,0);
    chk("lu_stall1", 0, ev(1,1,1,0,1,1,1,0));
    chk("lu_stall2", 0, ev(1,1,1,0,2,2,1,0));
    chk("lu_fwd", 0, ev(0,0,0,0,3,3,1,0));
    idle();
    chk("lu_after", 0, ev(0,0,0,0,0,0,1,0));
    chk("lu_d1", 0, ev(0,0,0,0,0,0,1,0));
    chk("lu_d2", 0, ev(0,0,0,0,0,0,1,0));

    instr(1, 0,0, 0,0, 7,1,1,0);
    chk("lw7", 0, ev(0,0,0,0,0,0,0,0));
    instr(1, 7,1, 0,0, 8,1,0,0);
    redirect = 1;
    chk("redir", 0, ev(0,0,1,1,1,0,1,0));
    idle();
    chk("redir_k1", 0, ev(0,0,0,0,0,0,1,0));
    chk("redir_k2", 0, ev(0,0,0,0,0,0,1,0));
    chk("redir_k3", 0, ev(0,0,0,0,0,0,0,0));

    instr(1, 0,0, 0,0, 1,1,0,0);
    chk("mb_w1", 0, ev(0,0,0,0,0,0,0,0));
    instr(1, 0,0, 0,0, 2,1,0,0);
    chk("mb_w2", 0, ev(0,0,0,0,0,0,1,0));
    instr(1, 0,0, 0,0, 3,1,0,0);
    chk("mb_w3", 0, ev(0,0,0,0,0,0,2,0));
    instr(1, 2,1, 1,1, 9,1,0,0);
    mem_busy = 1;
    for (int k = 0; k < 5; k++) begin
      chk("mb_hold", 0, ev(1,1,0,0,2,3,3,0));
    end
    mem_busy = 0;
    chk("mb_rel", 0, ev(0,0,0,0,2,3,3,0));
    instr(0, 3,1, 2,1, 0,0,0,0);
    chk("mb_sh1", 0, ev(0,0,0,0,2,3,3,0));
    instr(0, 9,1, 3,1, 0,0,0,0);
    chk("mb_sh2", 0, ev(0,0,0,0,2,3,2,0));
    idle();
    chk("mb_sh3", 0, ev(0,0,0,0,0,0,1,0));

    instr(1, 0,0, 0,0, 1,1,0,0);
    chk("h_w1", 0, ev(0,0,0,0,0,0,0,0));
    instr(1, 0,0, 0,0, 2,1,0,0);
    chk("h_w2", 0, ev(0,0,0,0,0,0,1,0));
    instr(1, 0,0, 0,0, 3,1,0,1);
    chk("h_issue", 0, ev(0,0,0,0,0,0,2,0));
    instr(1, 3,1, 0,0, 4,1,0,0);
    chk("h_drain3", 0, ev(1,1,1,0,0,0,3,0));
    idle();
    chk("h_drain2", 0, ev(1,1,1,0,0,0,2,0));
    chk("h_drain1", 0, ev(1,1,1,0,0,0,1,0));
    chk("h_halted", 0, ev(1,1,0,0,0,0,0,1));
    instr(1, 0,0, 0,0, 5,1,0,0);
    chk("h_hold", 0, ev(1,1,0,0,0,0,0,1));
    rst = 1;
    chk("h_rst", 0, ev(1,1,0,0,0,0,0,1));
    rst = 0;
    chk("h_run", 0, ev(0,0,0,0,0,0,0,0));
    idle();
    chk("h_run_cnt", 0, ev(0,0,0,0,0,0,1,0));

    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("b_rst", 1, ev(0,0,0,0,0,0,0,0));
    instr(1, 0,0, 0,0, 1,1,0,0);
    chk("b_w1", 1, ev(0,0,0,0,0,0,0,0));
    instr(1, 1,1, 0,0, 2,1,0,0);
    chk("b_st1", 1, ev(1,1,1,0,0,0,1,0));
    chk("b_st2", 1, ev(1,1,1,0,0,0,1,0));
    chk("b_st3", 1, ev(1,1,1,0,0,0,1,0));
    chk("b_go", 1, ev(0,0,0,0,0,0,0,0));
    instr(1, 0,0, 0,0, 0,1,0,0);
    chk("b_r0w", 1, ev(0,0,0,0,0,0,1,0));
    instr(1, 0,1, 0,1, 6,1,0,0);
    chk("b_r0r", 1, ev(0,0,0,0,0,0,2,0));
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
